// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling and a first-word-fall-through receive FIFO.
// Sticky frame/overrun flags; clkEn freezes every register in the block.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clkEn,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
    } rx_byte_t;

    logic          rx_meta, rx_s;
    logic [1:0]    vld_pipe;
    logic          armed;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          bit_done, frame_set, overrun_set;
    logic          do_push, do_pop;
    rx_byte_t      push;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // vld_pipe marks when rx_s holds a real pin sample rather than its reset value;
    // armed then requires a genuine high level before any start bit is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            vld_pipe <= '0;
            armed    <= 1'b0;
        end else if (clkEn) begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            vld_pipe <= {vld_pipe[0], 1'b1};
            armed    <= armed | (vld_pipe[1] & rx_s);
        end
    end

    assign bit_done = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else if (clkEn) begin
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // a held-low line (break) must not decode as a stream of 0x00
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        push.vld  = clkEn && (state == STOP) && bit_done && rx_s;
        push.data = shreg;
        frame_set = clkEn && (state == STOP) && bit_done && !rx_s;
    end

    assign rx_valid    = (fifo_count != '0);
    assign do_pop      = clkEn && rd_en && rx_valid;
    // a full FIFO still accepts the byte when the head is popped in the same cycle
    assign do_push     = push.vld && ((fifo_count != DEPTH_C) || do_pop);
    assign overrun_set = push.vld && !do_push;

    always_ff @(posedge clk) begin
        if (clkEn && do_push) mem[wr_ptr] <= push.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (clkEn) begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign rd_data = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (clkEn) begin
            frame_err <= (frame_err & ~err_clr) | frame_set;
            overrun   <= (overrun & ~err_clr) | overrun_set;
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver with a small receive FIFO for the RV32I SoC. It consumes the asynchronous `rx` pin driven by the host or bench at 8N1 framing, recovers bytes by mid-bit sampling and buffers them. It presents them to the SoC's UART peripheral register block through a first-word-fall-through pop interface. Default timing is 115200 baud from a 100 MHz clock, 868 clocks per bit.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clocks per serial bit; must be ≥ 4.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `clkEn` in 1: global enable; when 0 every register holds, including the synchronizer, FSM, counters, FIFO and flags.
- `rx` in 1: asynchronous serial input; idles high.
- `rd_en` in 1: pop the head entry; ignored when `rx_valid`=0.
- `rd_data` out 8: head byte; 8'h00 when the FIFO is empty.
- `rx_valid` out 1: FIFO non-empty.
- `fifo_count` out clog2(FIFO_DEPTH)+1: current occupancy.
- `frame_err` out 1: sticky; a stop bit sampled as 0.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.
- `err_clr` in 1: clears both sticky flags.

## Operation
- `rx` passes through a 2-flop synchronizer, producing `rx_s`; both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. A bit counter `cnt` runs 0..CLKS_PER_BIT-1, and a bit index `idx` runs 0..7.
- IDLE: `rx_s`=0 moves to START with `cnt`=0.
- START: when `cnt`=CLKS_PER_BIT/2-1 (433 by default), sample `rx_s`.
  - 0: go to DATA with `cnt`=0 and `idx`=0.
  - 1: false start; return to IDLE with no flag.
- DATA: when `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the shift register LSB-first and reset `cnt`. After the sample at `idx`=7, go to STOP; otherwise increment `idx`.
- STOP: when `cnt`=CLKS_PER_BIT-1, sample `rx_s`.
  - 1: push the byte and go to IDLE.
  - 0: set `frame_err`, discard the byte and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- Push to a full FIFO: the byte is dropped, `overrun` is set and FIFO contents are unchanged. Exception: if `rd_en` is also valid in that cycle, pop and push both occur and `fifo_count` stays at FIFO_DEPTH.
- Pop: `rd_en`=1 with `rx_valid`=1 advances the read pointer and decrements `fifo_count`.
- Simultaneous push and pop on a non-empty FIFO leaves `fifo_count` unchanged. On an empty FIFO the pop is ignored and the push lands.
- Pointers are clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
- Sticky flags: `err_clr` clears `frame_err` and `overrun`. If a set condition occurs in the same cycle as `err_clr`, the flag ends the cycle at 1 (set wins).

## Timing
- Reset values: `rd_data`=8'h00, `rx_valid`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0. FSM is in IDLE and pointers are 0.
- Reset asserted mid-frame aborts the frame. The partial byte is lost, no flag is set, and FSM restart requires a new falling edge after reset releases.
- Latency: the push occurs 434 + 9×868 = 8246 enabled cycles after the FSM enters START.
- `rx_valid` rises 8249 ±1 enabled clocks after the `rx` falling edge, comprising 2 synchronizer clocks, 1 IDLE detect clock, 8246 clocks to the push and the registered count.
- `rd_data` is combinational from FIFO memory at the read pointer. After a pop, the next entry appears in the following cycle.
- Back-to-back frames: a start bit beginning immediately after the stop-bit sample is accepted with no idle gap required.
- With `clkEn`=0 the block is frozen. Time measured in enabled cycles excludes frozen cycles.

## Test plan
- Reset, then send 0x51 as {stop, 8'h51, start} at 868 clocks/bit: `rx_valid` rises at 8249±1 cycles, `rd_data`=8'h51, `fifo_count`=1. After a 1-cycle `rd_en`: `rx_valid`=0 and `rd_data`=8'h00.
- Send 0x00, 0xFF, 0xA5, 0x3C back-to-back without popping: `fifo_count`=4 and `overrun`=0. Pops return the bytes in that order; count reaches 0 after the 4th pop.
- Send 5 bytes 0x01..0x05 with no pops: `fifo_count`=4 and `overrun`=1. FIFO holds 0x01..0x04. Pulse `err_clr`: `overrun`=0.
- Frame 0x7E with the stop bit held 0 for 3 bit-times, then idle high, then send 0x42: `frame_err`=1, 0x7E never appears, `rx` held low yields no 0x00 bytes, and the only FIFO entry is 0x42.
- Glitch `rx` low for 100 clocks, then high: FSM returns to IDLE, and `rx_valid` and the flags stay 0. A following valid 0x33 is received correctly.
- Assert `rst` 3000 clocks into a 0x99 frame, release it, then send 0x66: FIFO contains only 0x66 and the flags are 0. Separately, hold `clkEn`=0 for 500 cycles mid-frame while freezing `rx`: the byte is still received correctly.
